cfg_port_arbiter: RTL and testbench

CFG_PORT_ARBITER -- requirements
Module: cfg_port_arbiter

---
 rtl/cfg_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_cfg_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_port_arbiter.sv
// Shares one config-space read port among three requesters using round-robin
// arbitration. A read that gets no completion within TIMEOUT_CYCLES is aborted.
module cfg_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_req,
    input  logic [9:0]  i_addr0,
    input  logic [9:0]  i_addr1,
    input  logic [9:0]  i_addr2,
    output logic [2:0]  o_ack,
    output logic [31:0] o_data,
    output logic        o_timeout,
    output logic [2:0]  o_grant,
    output logic        o_busy,
    output logic [9:0]  o_cfg_dwaddr,
    output logic        o_cfg_rd_en,
    input  logic [31:0] i_cfg_do,
    input  logic        i_cfg_rd_wr_done
);
    // Handshakes: i_req[n] is a level held until o_ack[n] pulses for one cycle
    // (o_data is valid in that cycle); i_cfg_rd_wr_done is a level that must fall
    // before the port is released to the next requester.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  last_grant, last_grant_nxt;
    logic [15:0] count, count_nxt;
    logic [2:0]  ack_nxt, grant_nxt;
    logic [31:0] data_nxt;
    logic        timeout_nxt, busy_nxt, rd_en_nxt;
    logic [9:0]  dwaddr_nxt;
    logic [1:0]  cand0, cand1, cand2, pick;
    logic        pick_valid;
    logic        count_done;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign count_done = (count == COUNT_LAST);

    // Search order starts just after the previous winner.
    always_comb begin
        cand0      = rr_next(last_grant);
        cand1      = rr_next(cand0);
        cand2      = rr_next(cand1);
        pick       = cand0;
        pick_valid = 1'b1;
        if (i_req[cand0])      pick = cand0;
        else if (i_req[cand1]) pick = cand1;
        else if (i_req[cand2]) pick = cand2;
        else                   pick_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 2'd2;
            count        <= 16'd0;
            o_ack        <= 3'b000;
            o_data       <= 32'd0;
            o_timeout    <= 1'b0;
            o_grant      <= 3'b000;
            o_busy       <= 1'b0;
            o_cfg_dwaddr <= 10'd0;
            o_cfg_rd_en  <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            count        <= count_nxt;
            o_ack        <= ack_nxt;
            o_data       <= data_nxt;
            o_timeout    <= timeout_nxt;
            o_grant      <= grant_nxt;
            o_busy       <= busy_nxt;
            o_cfg_dwaddr <= dwaddr_nxt;
            o_cfg_rd_en  <= rd_en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_valid) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (i_cfg_rd_wr_done || count_done) state_nxt = RELEASE;
            RELEASE:   if (!i_cfg_rd_wr_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; a completion beats a coincident timeout.
    always_comb begin
        grant_nxt      = o_grant;
        dwaddr_nxt     = o_cfg_dwaddr;
        data_nxt       = o_data;
        last_grant_nxt = last_grant;
        count_nxt      = count;
        ack_nxt        = 3'b000;
        timeout_nxt    = 1'b0;
        rd_en_nxt      = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt      = 3'b001 << pick;
                    last_grant_nxt = pick;
                    case (pick)
                        2'd0:    dwaddr_nxt = i_addr0;
                        2'd1:    dwaddr_nxt = i_addr1;
                        default: dwaddr_nxt = i_addr2;
                    endcase
                end
            end
            ISSUE: begin
                count_nxt = 16'd0;
                rd_en_nxt = 1'b1;
            end
            WAIT_DONE: begin
                if (i_cfg_rd_wr_done) begin
                    data_nxt = i_cfg_do;
                    ack_nxt  = o_grant;
                end else if (count_done) begin
                    data_nxt    = 32'hFFFF_FFFF;
                    ack_nxt     = o_grant;
                    timeout_nxt = 1'b1;
                end else begin
                    count_nxt = count + 16'd1;
                    rd_en_nxt = 1'b1;
                end
            end
            RELEASE: begin
                if (!i_cfg_rd_wr_done) grant_nxt = 3'b000;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cfg_port_arbiter.sv
// Self-checking bench for cfg_port_arbiter: table of single reads plus
// contention, mid-read reset and ignored-request sequences.
module tb_cfg_port_arbiter;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  i_req;
    logic [9:0]  i_addr0, i_addr1, i_addr2;
    logic [2:0]  o_ack;
    logic [31:0] o_data;
    logic        o_timeout;
    logic [2:0]  o_grant;
    logic        o_busy;
    logic [9:0]  o_cfg_dwaddr;
    logic        o_cfg_rd_en;
    logic [31:0] i_cfg_do;
    logic        i_cfg_rd_wr_done;

    typedef struct {
        int          r;
        logic [9:0]  addr;
        int          delay;
        logic        ovr;
        logic [31:0] do_val;
        int          hold;
        logic [2:0]  exp_ack;
        logic [31:0] exp_data;
        logic        exp_tmo;
    } vec_t;

    vec_t        vecs[6];
    logic [35:0] exp_q[$];
    logic [35:0] exp_entry;
    int          checks = 0;
    int          errors = 0;

    cfg_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req            (i_req),
        .i_addr0          (i_addr0),
        .i_addr1          (i_addr1),
        .i_addr2          (i_addr2),
        .o_ack            (o_ack),
        .o_data           (o_data),
        .o_timeout        (o_timeout),
        .o_grant          (o_grant),
        .o_busy           (o_busy),
        .o_cfg_dwaddr     (o_cfg_dwaddr),
        .o_cfg_rd_en      (o_cfg_rd_en),
        .i_cfg_do         (i_cfg_do),
        .i_cfg_rd_wr_done (i_cfg_rd_wr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input int r);
        case (r)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [31:0] cfg_mem(input logic [9:0] a);
        return 32'hF000_0000 + {22'd0, a} * 32'd3;
    endfunction

    task automatic set_addr(input int r, input logic [9:0] a);
        case (r)
            0:       i_addr0 = a;
            1:       i_addr1 = a;
            default: i_addr2 = a;
        endcase
    endtask

    // Config-port model: answers one read, done raised after d observed rd_en
    // cycles (d < 0: never), then held for `hold` extra cycles.
    task automatic serve(input int d, input logic [9:0] exp_addr, input int r,
                         input logic ovr, input logic [31:0] ovr_val, input int hold);
        int n;
        int hi;
        n = 0;
        while (!o_cfg_rd_en && n < 20) begin
            tick();
            n++;
        end
        check("rd_en_rise", 32'(o_cfg_rd_en), 32'd1);
        if (!o_cfg_rd_en) return;
        check("serve_grant", 32'(o_grant), 32'(onehot(r)));
        check("dwaddr", 32'(o_cfg_dwaddr), 32'(exp_addr));
        i_cfg_do = ovr ? ovr_val : cfg_mem(o_cfg_dwaddr);
        hi = 0;
        while (o_cfg_rd_en && hi < 40) begin
            hi++;
            if (d >= 0 && hi == d + 1) i_cfg_rd_wr_done = 1'b1;
            tick();
        end
        check("rd_en_cycles", 32'(hi), 32'((d >= 0) ? d + 1 : T));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("sticky_release", 32'({o_busy, o_cfg_rd_en, o_grant}), 32'({1'b1, 1'b0, onehot(r)}));
        end
        i_cfg_rd_wr_done = 1'b0;
        tick();
        check("release_idle", 32'({o_busy, o_grant, o_cfg_rd_en}), 32'd0);
    endtask

    // Scoreboard: every ack/timeout pulse pops one expected record.
    always @(negedge clk) begin
        if (!rst && (o_ack != 3'b000 || o_timeout)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=%b timeout=%b data=%h, required no completion",
                         o_ack, o_timeout, o_data);
            end else begin
                exp_entry = exp_q.pop_front();
                if ({o_ack, o_timeout, o_data} !== exp_entry) begin
                    errors++;
                    $display("FAIL completion: ack=%b timeout=%b data=%h, required ack=%b timeout=%b data=%h",
                             o_ack, o_timeout, o_data, exp_entry[35:33], exp_entry[32], exp_entry[31:0]);
                end
            end
        end
    end

    initial begin
        int n;
        vecs[0] = '{0, 10'h004, 3,  1'b0, 32'h0,         0, 3'b001, 32'hF000_000C, 1'b0};
        vecs[1] = '{1, 10'h3FF, 0,  1'b0, 32'h0,         0, 3'b010, 32'hF000_0BFD, 1'b0};
        vecs[2] = '{2, 10'h0AA, -1, 1'b0, 32'h0,         0, 3'b100, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{0, 10'h123, 7,  1'b1, 32'h1234_5678, 0, 3'b001, 32'h1234_5678, 1'b0};
        vecs[4] = '{1, 10'h200, 6,  1'b1, 32'hDEAD_BEEF, 0, 3'b010, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{2, 10'h010, 2,  1'b0, 32'h0,         5, 3'b100, 32'hF000_0030, 1'b0};

        rst = 1'b1;
        i_req = 3'b000;
        i_addr0 = 10'd0;
        i_addr1 = 10'd0;
        i_addr2 = 10'd0;
        i_cfg_do = 32'd0;
        i_cfg_rd_wr_done = 1'b0;
        repeat (3) tick();
        check("reset_data", o_data, 32'd0);
        check("reset_ctrl", 32'({o_ack, o_timeout, o_grant, o_busy, o_cfg_rd_en, o_cfg_dwaddr}), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", 32'({o_grant, o_busy}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            set_addr(vecs[i].r, vecs[i].addr);
            i_req = onehot(vecs[i].r);
            exp_q.push_back({vecs[i].exp_ack, vecs[i].exp_tmo, vecs[i].exp_data});
            n = 0;
            tick();
            while (o_grant == 3'b000 && n < 20) begin
                tick();
                n++;
            end
            check("grant", 32'(o_grant), 32'(vecs[i].exp_ack));
            check("setup_cycle", 32'({o_busy, o_cfg_rd_en}), 32'b10);
            // Requester withdraws and changes its address; the read must proceed unchanged.
            i_req = 3'b000;
            set_addr(vecs[i].r, ~vecs[i].addr);
            serve(vecs[i].delay, vecs[i].addr, vecs[i].r, vecs[i].ovr, vecs[i].do_val, vecs[i].hold);
            check("data_hold", o_data, vecs[i].exp_data);
        end

        i_addr0 = 10'h004;
        i_addr1 = 10'h005;
        i_addr2 = 10'h006;
        i_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({onehot(k % 3), 1'b0, cfg_mem(10'h004 + 10'(k % 3))});
            serve(1, 10'h004 + 10'(k % 3), k % 3, 1'b0, 32'h0, 0);
        end
        i_req = 3'b000;

        set_addr(0, 10'h02A);
        i_req = 3'b001;
        n = 0;
        tick();
        while (!o_cfg_rd_en && n < 20) begin
            tick();
            n++;
        end
        check("midread_rd_en", 32'(o_cfg_rd_en), 32'd1);
        i_req = 3'b000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ctrl", 32'({o_cfg_rd_en, o_grant, o_busy, o_ack, o_timeout}), 32'd0);
        check("midrst_data", o_data, 32'd0);
        check("midrst_dwaddr", 32'(o_cfg_dwaddr), 32'd0);
        repeat (10) tick();
        check("midrst_idle", 32'({o_grant, o_busy}), 32'd0);
        set_addr(1, 10'h155);
        i_req = 3'b010;
        exp_q.push_back({3'b010, 1'b0, cfg_mem(10'h155)});
        serve(3, 10'h155, 1, 1'b0, 32'h0, 0);
        i_req = 3'b000;

        // A request raised and dropped while busy must be forgotten.
        set_addr(0, 10'h0F0);
        i_req = 3'b001;
        exp_q.push_back({3'b001, 1'b0, cfg_mem(10'h0F0)});
        tick();
        check("busy_grant", 32'(o_grant), 32'b001);
        i_req = 3'b100;
        tick();
        tick();
        i_req = 3'b000;
        serve(2, 10'h0F0, 0, 1'b0, 32'h0, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_queued_grant", 32'({o_grant, o_busy}), 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
